// File: rtl/updn_mon_pkg.sv
// Shared types for the up/down counter sequence monitor.
package updn_mon_pkg;
  typedef enum logic [1:0] {
    ACQ    = 2'b00,
    TRAIN  = 2'b01,
    TRK_UP = 2'b10,
    TRK_DN = 2'b11
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/updn_mon_watchdog.sv
// Idle watchdog for updn_seq_monitor: counts enabled cycles, fires once at TIMEOUT.
module updn_mon_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Fires on the cycle that would make the count reach TIMEOUT; clear wins.
  assign expire = count_en && !clear && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_cnt <= '0;
    else if (clear || expire)  r_cnt <= '0;
    else if (count_en)         r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/updn_seq_monitor.sv
// Up/down counter sequence monitor: locks on direction, predicts steps incl. turnarounds.
// Optional idle watchdog compiled in with UPDN_MON_WATCHDOG_EN.
module updn_seq_monitor
  import updn_mon_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int MAX     = 3,
  parameter int ERR_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             dir,
  output logic             turn,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             stall
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t           r_state, w_nxt_state;
  logic [WIDTH-1:0] r_prev, w_nxt_prev;
  logic             r_turn, r_err, w_turn, w_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_legal, w_step_up, w_step_dn, w_top, w_bot, w_locked, w_expire;

  // Step detection guarded at the ends so nothing wraps modulo 2^WIDTH.
  assign w_legal   = (count_in <= MAX_V);
  assign w_top     = (r_prev == MAX_V);
  assign w_bot     = (r_prev == '0);
  assign w_step_up = (r_prev != '1) && (count_in == r_prev + ONE);
  assign w_step_dn = !w_bot && (count_in == r_prev - ONE);
  assign w_locked  = (r_state == TRK_UP) || (r_state == TRK_DN);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_prev  = r_prev;
    w_turn      = 1'b0;
    w_err       = 1'b0;
    if (valid) begin
      w_nxt_prev = count_in;
      case (r_state)
        ACQ: w_nxt_state = TRAIN;
        TRAIN: begin
          if (w_legal && w_step_up)      w_nxt_state = TRK_UP;
          else if (w_legal && w_step_dn) w_nxt_state = TRK_DN;
          else                           w_err = 1'b1;
        end
        TRK_UP: begin
          if (w_legal && w_top && w_step_dn) begin
            w_nxt_state = TRK_DN;
            w_turn      = 1'b1;
          end else if (!(w_legal && !w_top && w_step_up)) begin
            w_nxt_state = TRAIN;
            w_err       = 1'b1;
          end
        end
        TRK_DN: begin
          if (w_legal && w_bot && w_step_up) begin
            w_nxt_state = TRK_UP;
            w_turn      = 1'b1;
          end else if (!(w_legal && !w_bot && w_step_dn)) begin
            w_nxt_state = TRAIN;
            w_err       = 1'b1;
          end
        end
        default: w_nxt_state = ACQ;
      endcase
    end else if (w_expire) begin
      w_nxt_state = ACQ;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ACQ;
      r_prev    <= '0;
      r_turn    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_prev  <= w_nxt_prev;
      r_turn  <= w_turn;
      r_err   <= w_err;
      if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

`ifdef UPDN_MON_WATCHDOG_EN
  logic r_stall;

  updn_mon_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .clear    (valid),
    .count_en (w_locked && !valid),
    .expire   (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_stall <= 1'b0;
    else        r_stall <= w_expire;
  end

  assign stall = r_stall;
`else
  assign w_expire = 1'b0;
  assign stall    = 1'b0;
`endif

  assign locked    = w_locked;
  assign dir       = (r_state == TRK_DN) ? DIR_DN : DIR_UP;
  assign turn      = r_turn;
  assign err       = r_err;
  assign err_count = r_err_cnt;
endmodule

// File: tb/tb_updn_seq_monitor.sv
// Self-checking bench for updn_seq_monitor: vector table plus corner-case sequences.
module tb_updn_seq_monitor;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] count_in = '0;
  logic       locked, dir, turn, err, stall;
  logic [7:0] err_count;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  typedef struct {
    logic v; logic [1:0] c; logic l; logic d; logic t; logic e;
  } vec_t;

  typedef struct {
    string nm; logic l; logic d; logic t; logic e; logic s; int cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];

  updn_seq_monitor #(.WIDTH(2), .MAX(3), .ERR_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .valid(valid), .count_in(count_in),
    .locked(locked), .dir(dir), .turn(turn), .err(err),
    .err_count(err_count), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Drive one cycle, push expectation, compare after the edge.
  task automatic step(input logic v, input logic [1:0] c, input logic el, input logic ed,
                      input logic et, input logic ee, input logic es, input string nm);
    exp_t e;
    exp_t g;
    @(negedge clk);
    valid = v; count_in = c;
    if (ee && exp_cnt < 255) exp_cnt++;
    e.nm = nm; e.l = el; e.d = ed; e.t = et; e.e = ee; e.s = es; e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      g = sb.pop_front();
      chk({g.nm, ".locked"}, int'(locked), int'(g.l));
      if (g.l) chk({g.nm, ".dir"}, int'(dir), int'(g.d));
      chk({g.nm, ".turn"}, int'(turn), int'(g.t));
      chk({g.nm, ".err"}, int'(err), int'(g.e));
      chk({g.nm, ".stall"}, int'(stall), int'(g.s));
      chk({g.nm, ".err_count"}, int'(err_count), g.cnt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; valid = 1'b0; count_in = '0; exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.locked", int'(locked), 0);
    chk("rst.dir", int'(dir), 0);
    chk("rst.turn", int'(turn), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.err_count", int'(err_count), 0);
    chk("rst.stall", int'(stall), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // v, c, locked, dir, turn, err
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};  // ACQ capture
    tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};  // lock up
    tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0};  // turn at MAX
    tbl[5]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0};  // turn at 0
    tbl[8]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1};  // mismatch -> TRAIN
    tbl[9]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};  // relock down
    tbl[10] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1};  // repeat -> err
    tbl[11] = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};  // held value not checked
    tbl[12] = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0};  // TRAIN 2->1 locks down

    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].c, tbl[i].l, tbl[i].d, tbl[i].t, tbl[i].e, 1'b0,
           $sformatf("vec%0d", i));
      if (i == 11) for (int k = 0; k < 9; k++) step(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "hold");
    end

    // Saturation: capture 0 then 300 repeats of 0.
    do_reset();
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sat.cap");
    for (int i = 0; i < 300; i++) step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "sat");
    chk("sat.final", int'(err_count), 255);

    // Idle while locked: watchdog expiry (or nothing, without the watchdog).
    do_reset();
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "wd.cap");
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "wd.lock");
    for (int k = 1; k <= 17; k++) begin
`ifdef UPDN_MON_WATCHDOG_EN
      step(1'b0, 2'd1, (k < 16), 1'b0, 1'b0, 1'b0, (k == 16), $sformatf("wd.idle%0d", k));
`else
      step(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("wd.idle%0d", k));
`endif
    end
`ifdef UPDN_MON_WATCHDOG_EN
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "wd.acq");   // fresh capture
`else
    step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "wd.acq");   // still tracking up
`endif
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "wd.bad");

    // Valid in the would-be expiry cycle keeps tracking.
    do_reset();
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pri.cap");
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pri.lock");
    for (int k = 1; k <= 15; k++) step(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pri.idle");
    step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pri.step");
    step(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pri.after");

    // Async reset while locked down with a nonzero error count.
    do_reset();
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ar.cap");
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ar.rep");
    step(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ar.dn");
    step(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ar.dn2");
    #2 reset = 1'b0;
    #1;
    chk("ar.locked", int'(locked), 0);
    chk("ar.dir", int'(dir), 0);
    chk("ar.err_count", int'(err_count), 0);
    chk("ar.turn", int'(turn), 0);
    chk("ar.err", int'(err), 0);
    chk("ar.stall", int'(stall), 0);
    exp_cnt = 0;
    @(negedge clk);
    valid = 1'b0;
    reset = 1'b1;
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ar.cap2");
    step(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ar.relock");

    chk("sb.empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/updn_seq_monitor.md
# updn_seq_monitor

Receive-side monitor for the up/down counter interface. It samples a counter value bus on a per-step strobe, locks onto the counting direction, and predicts every following value, including the turnaround at MAX and at 0. It reports direction, turnaround events and sequence errors. It sits on the consumer side of any up/down counter block and is used both in the design and as a bench checker.

## Interface
- WIDTH, 2, width of the observed count bus
- MAX, 3, top value at which the observed counter turns from up to down; must be ≥ 2 and ≤ 2^WIDTH−1
- ERR_W, 8, width of the error counter
- TIMEOUT, 16, watchdog idle limit in clk cycles (used only with the watchdog compiled in)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- valid  in  1  count_in carries a new counter step this cycle
- count_in  in  WIDTH  observed counter value
- locked  out  1  direction acquired, predictions active
- dir  out  1  0 = counting up, 1 = counting down; meaningful only while locked
- turn  out  1  one-cycle pulse on a correctly predicted turnaround
- err  out  1  one-cycle pulse on a mismatching or illegal step
- err_count  out  ERR_W  saturating count of err pulses
- stall  out  1  one-cycle pulse on watchdog expiry

## Operation
- State machine states: ACQ, TRAIN, TRK_UP, TRK_DN. A prev register holds the last accepted sample.
- ACQ: first valid captures prev = count_in and moves to TRAIN. No err is possible in ACQ.
- TRAIN: a valid step compares count_in with prev.
  - count_in == prev+1 goes to TRK_UP.
  - count_in == prev−1 goes to TRK_DN.
  - prev==MAX and count_in==MAX−1 goes to TRK_DN.
  - prev==0 and count_in==1 goes to TRK_UP.
  - Any other value pulses err and stays in TRAIN.
  - prev is always updated to count_in.
- TRK_UP: expected value is prev+1. If prev==MAX, the expected value is MAX−1 instead, the state moves to TRK_DN and turn pulses.
- TRK_DN: expected value is prev−1. If prev==0, the expected value is 1 instead, the state moves to TRK_UP and turn pulses.
- Mismatch while tracking: err pulses, the state goes to TRAIN, prev = count_in, and turn is suppressed.
- A repeated value (count_in == prev on valid) is an error in TRAIN, TRK_UP and TRK_DN.
- A value above MAX is always an error. It is still loaded into prev.
- With valid low, nothing changes. The held value is not checked.
- locked = state is TRK_UP or TRK_DN. dir = (state == TRK_DN).
- err_count increments on every err and saturates at 2^ERR_W−1. Only reset clears it.
- Arithmetic is done in WIDTH bits. Turnaround is handled explicitly, so no value ever wraps modulo 2^WIDTH.

## Timing
- All outputs are registered. A response appears on the rising edge after the clk edge that samples valid.
- Latency from a valid sample to err, turn, locked or dir is 1 cycle.
- turn, err and stall are single-cycle pulses. Back-to-back valid steps give back-to-back pulses.
- Reset values: state = ACQ, prev = 0, locked = 0, dir = 0, turn = 0, err = 0, err_count = 0, stall = 0, watchdog = 0.
- Reset asserted mid-stream clears everything asynchronously. The first valid after release acts as an ACQ capture.
- One step per clock is supported, with no throughput limit.

## Configuration
- UPDN_MON_WATCHDOG_EN defined:
  - An idle counter clears on every valid and counts clk cycles while the block is locked with valid low.
  - When the count reaches TIMEOUT, stall pulses, the state goes to ACQ and the counter clears.
  - err and err_count are untouched.
  - A valid arriving in the expiry cycle has priority: no stall, and normal checking applies.
- UPDN_MON_WATCHDOG_EN not defined: the idle counter is not built, stall is tied to 0, and TIMEOUT is ignored.

## Structure
- Shared package updn_mon_pkg holds:
  - state typedef: ACQ = 2'b00, TRAIN = 2'b01, TRK_UP = 2'b10, TRK_DN = 2'b11
  - DIR_UP = 1'b0 and DIR_DN = 1'b1
- One sub-module, updn_mon_watchdog: the idle counter with inputs clear and count_en and an expire output. It is instantiated only under UPDN_MON_WATCHDOG_EN.

## Test plan
- Reset, then the valid stream 0,1,2,3,2,1,0,1. Expected: locked rises after the second sample with dir=0; turn pulses after the 3→2 step and after the 0→1 step; dir becomes 1 then 0; err never asserts.
- Locked up at prev=1, then inject count_in=3. Expected: err pulse one cycle later, err_count=1, locked=0, state TRAIN; the next valid 2 re-locks with dir=1.
- Repeat count_in=2 twice with valid high. Expected: err pulse on the second sample. Then the same value with valid low for 10 cycles: no err.
- Drive 300 illegal steps with ERR_W=8. Expected: err_count saturates at 255.
- Watchdog build, TIMEOUT=16: lock, then hold valid low for 16 cycles. Expected: stall pulse, locked=0, and the next valid is treated as an ACQ capture. Non-watchdog build: stall stays 0.
- Assert reset mid-stream while locked down. Expected: all outputs go to 0 immediately, without a clk edge, and err_count is cleared.
